// File: rtl/ex_muldiv_unit_pkg.sv
// ============================================================================
//  Module      : ex_muldiv_unit_pkg
//  Description : Shared constants for the RV32IM EX-stage multiply/divide
//                unit: operand width, divider counter width, M-extension
//                ALU_SELECT codes and an M-code decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // ALU_SELECT codes are {2'b00, 1'b1, funct3}
    localparam logic [5:0] ALU_MUL    = 6'b001000;
    localparam logic [5:0] ALU_MULH   = 6'b001001;
    localparam logic [5:0] ALU_MULHSU = 6'b001010;
    localparam logic [5:0] ALU_MULHU  = 6'b001011;
    localparam logic [5:0] ALU_DIV    = 6'b001100;
    localparam logic [5:0] ALU_DIVU   = 6'b001101;
    localparam logic [5:0] ALU_REM    = 6'b001110;
    localparam logic [5:0] ALU_REMU   = 6'b001111;

    // True when the select code belongs to the M extension
    function automatic logic is_m_code(input logic [5:0] sel);
        return (sel[5:3] == 3'b001);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_core.sv
// ============================================================================
//  Module      : muldiv_div_core
//  Description : Iterative radix-2 restoring divider on unsigned magnitudes.
//                One quotient bit per step; 'last' flags the final step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_div_core
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,      // asynchronous, active-low
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [XLEN-1:0]  r_divisor;
    logic [CNT_W-1:0] r_count;
    logic [XLEN:0]    w_shifted;
    logic [XLEN:0]    w_diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        w_shifted = {remainder, quotient[XLEN-1]};
        w_diff    = w_shifted - {1'b0, r_divisor};
    end

    assign last = (r_count == LAST_CNT);

    // Quotient register doubles as the dividend shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient  <= '0;
            remainder <= '0;
            r_divisor <= '0;
            r_count   <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            r_divisor <= divisor;
            r_count   <= '0;
        end else if (step) begin
            // No borrow means the divisor fits: keep the difference
            if (!w_diff[XLEN]) begin
                remainder <= w_diff[XLEN-1:0];
            end else begin
                remainder <= w_shifted[XLEN-1:0];
            end
            quotient <= {quotient[XLEN-2:0], ~w_diff[XLEN]};
            r_count  <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : RV32IM EX-stage multiply/divide unit. MUL* finishes in two
//                cycles; DIV/REM uses a 32-step restoring divider. Stalls the
//                upstream pipeline until the result is presented with DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,      // asynchronous, active-low
    input  logic            start,
    input  logic            kill,
    input  logic [5:0]      alu_select,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            stall
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [1:0]      r_op_lo;           // funct3[1:0] of the accepted op
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic            r_sign_q;
    logic            r_sign_r;

    logic            w_accept;
    logic            w_in_div;
    logic            w_in_signed;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div_load;
    logic            w_div_step;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic            w_div_last;
    logic [63:0]     w_mul_a;
    logic [63:0]     w_mul_b;
    logic [63:0]     w_product;
    logic [XLEN-1:0] w_mul_result;
    logic [XLEN-1:0] w_fix_result;

    // Decode the incoming op and resolve divide special cases up front
    always_comb begin
        w_accept      = (r_state == ST_IDLE) && start && is_m_code(alu_select) && !kill;
        w_in_div      = alu_select[2];
        w_in_signed   = !alu_select[0];
        w_div_zero    = (operand2 == '0);
        w_overflow    = w_in_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                        && (operand2 == '1);
        w_special     = w_div_zero || w_overflow;
        if (w_div_zero) begin
            w_special_val = alu_select[1] ? operand1 : '1;
        end else begin
            w_special_val = alu_select[1] ? '0 : operand1;
        end
        w_mag1 = (w_in_signed && operand1[XLEN-1]) ? -operand1 : operand1;
        w_mag2 = (w_in_signed && operand2[XLEN-1]) ? -operand2 : operand2;
    end

    // Sign-extend to 64 bits; the low 64 product bits equal those of a 66-bit
    // multiply of 33-bit extended operands. MULHU is the only fully unsigned op,
    // and only MULH treats rs2 as signed (MUL's low half is sign-agnostic).
    always_comb begin
        w_mul_a      = {{32{(r_op_lo != 2'b11) & r_op_a[XLEN-1]}}, r_op_a};
        w_mul_b      = {{32{(r_op_lo == 2'b01) & r_op_b[XLEN-1]}}, r_op_b};
        w_product    = w_mul_a * w_mul_b;
        w_mul_result = (r_op_lo == 2'b00) ? w_product[31:0] : w_product[63:32];
        if (r_op_lo[1]) begin
            w_fix_result = r_sign_r ? -w_rem : w_rem;
        end else begin
            w_fix_result = r_sign_q ? -w_quo : w_quo;
        end
    end

    muldiv_div_core u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (w_div_load),
        .step      (w_div_step),
        .dividend  (w_mag1),
        .divisor   (w_mag2),
        .quotient  (w_quo),
        .remainder (w_rem),
        .last      (w_div_last)
    );

    // Next-state and divider controls; KILL overrides everything
    always_comb begin
        w_state_next = r_state;
        w_div_load   = 1'b0;
        w_div_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_in_div) begin
                        w_state_next = ST_MUL;
                    end else if (w_special) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_DIV;
                        w_div_load   = 1'b1;
                    end
                end
            end
            ST_MUL:  w_state_next = ST_DONE;
            ST_DIV: begin
                w_div_step = 1'b1;
                if (w_div_last) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX:  w_state_next = ST_DONE;
            // ID/EX still shows the completed op here, so START is ignored
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (kill) begin
            w_state_next = ST_IDLE;
            w_div_load   = 1'b0;
            w_div_step   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, sign capture and RESULT register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_lo  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            result   <= '0;
        end else begin
            if (w_accept) begin
                r_op_lo  <= alu_select[1:0];
                r_op_a   <= operand1;
                r_op_b   <= operand2;
                r_sign_q <= w_in_signed && (operand1[XLEN-1] ^ operand2[XLEN-1]);
                r_sign_r <= w_in_signed && operand1[XLEN-1];
                if (w_in_div && w_special) begin
                    result <= w_special_val;
                end
            end
            if (!kill && (r_state == ST_MUL)) begin
                result <= w_mul_result;
            end
            if (!kill && (r_state == ST_FIX)) begin
                result <= w_fix_result;
            end
        end
    end

    assign done  = (r_state == ST_DONE);
    // Held low during reset so the pipeline is never frozen by a stale START
    assign stall = reset && (w_accept || (r_state == ST_MUL) ||
                             (r_state == ST_DIV) || (r_state == ST_FIX));

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Self-checking bench for ex_muldiv_unit: directed vector
//                table, randomized ops against an arithmetic reference model,
//                and hand sequences for KILL, reset and back-to-back issue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [5:0]  alu_select;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kill       (kill),
        .alu_select (alu_select),
        .operand1   (operand1),
        .operand2   (operand2),
        .result     (result),
        .done       (done),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the RISC-V M semantics
    function automatic logic [31:0] model(input logic [5:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (sel)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            ALU_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            ALU_REM: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            ALU_REMU: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [5:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!sel[2]) return 2;
        if (b == 0) return 1;
        if ((sel == ALU_DIV || sel == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    // Issue one op from an IDLE negedge, scramble operands while it runs,
    // check latency, result and the stall profile, then leave one idle cycle.
    task automatic run_op(input string name, input logic [5:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          got = -1;
        logic [31:0] res = '0;
        logic        stall_ok;
        alu_select = sel;
        operand1   = a;
        operand2   = b;
        start      = 1'b1;
        #1 stall_ok = (stall === 1'b1);
        for (int cyc = 1; cyc <= 60 && got < 0; cyc++) begin
            @(posedge clk);
            #1;
            operand1 = $urandom;
            operand2 = $urandom;
            @(negedge clk);
            if (done === 1'b1) begin
                got = cyc;
                res = result;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        start = 1'b0;
        if (got < 0) begin
            check({name, " timeout"}, 32'(got), 32'(lat));
        end else begin
            check({name, " result"}, res, exp);
            check({name, " latency"}, 32'(got), 32'(lat));
            check({name, " stall"}, 32'(stall_ok), 32'd1);
        end
        @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        int          ndone;
        logic        res_ok;
        logic [5:0]  sel;
        logic [31:0] a, b;

        vecs[0]  = '{ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
        vecs[2]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[3]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{ALU_DIVU,   32'd100,       32'd7,         32'd14,        34};
        vecs[7]  = '{ALU_REMU,   32'd100,       32'd7,         32'd2,         34};
        vecs[8]  = '{ALU_DIVU,   32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{ALU_REM,    32'h0000_1234, 32'h0,         32'h0000_1234, 1};
        vecs[10] = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

        reset = 1'b1; start = 1'b0; kill = 1'b0;
        alu_select = '0; operand1 = '0; operand2 = '0;
        #2 reset = 1'b0;

        // Reset state, with a live START that must not raise STALL
        @(negedge clk);
        start = 1'b1; alu_select = ALU_MUL;
        #1;
        check("reset result", result, 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Non-M code with START is ignored
        start = 1'b1; alu_select = 6'b000010;
        #1 check("non-M stall", 32'(stall), 32'h0);
        @(negedge clk);
        check("non-M done", 32'(done), 32'h0);
        check("non-M idle stall", 32'(stall), 32'h0);
        start = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 120; i++) begin
            sel = {3'b001, 3'($urandom_range(0, 7))};
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 100);
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), sel, a, b, model(sel, a, b), model_lat(sel, a, b));
        end

        // KILL in cycle 10 of a DIV, then a MUL issued the next cycle
        run_op("pre-kill", ALU_MUL, 32'd6, 32'd7, 32'd42, 2);
        ndone = 0;
        start = 1'b1; alu_select = ALU_DIV; operand1 = 32'd1000; operand2 = 32'd3;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        kill = 1'b1; start = 1'b0;
        @(negedge clk);
        kill = 1'b0;
        if (done === 1'b1) ndone++;
        check("kill no done", 32'(ndone), 32'd0);
        check("kill stall", 32'(stall), 32'h0);
        check("kill result held", result, 32'd42);
        run_op("post-kill mul", ALU_MUL, 32'd9, 32'd9, 32'd81, 2);

        // Asynchronous reset in cycle 20 of a DIV
        run_op("pre-reset", ALU_MUL, 32'd3, 32'd5, 32'd15, 2);
        start = 1'b1; alu_select = ALU_DIVU; operand1 = 32'd5000; operand2 = 32'd7;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset result", result, 32'h0);
        check("async reset stall", 32'(stall), 32'h0);
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("reset discards op", 32'(ndone), 32'd0);

        // Back-to-back: START held continuously, one DONE every three cycles
        ndone  = 0;
        res_ok = 1'b1;
        start = 1'b1; alu_select = ALU_MULHU; operand1 = 32'hFFFF_FFFF; operand2 = 32'hFFFF_FFFF;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (result !== 32'hFFFF_FFFE) res_ok = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b done count", 32'(ndone), 32'd10);
        check("b2b results", 32'(res_ok), 32'd1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
